// File: rtl/uart_rx_core_if.sv
// Host-side receive handshake bundle between uart_rx_core and the SIF register block.
interface uart_rx_core_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] RX_DATA;
  logic              RX_RDY;
  logic              RX_FERR;
  logic              RX_PERR;
  logic              RX_OVR;
  logic              RX_ACK;

  // Receive core drives the byte and status, host returns the acknowledge.
  modport master (
    output RX_DATA, RX_RDY, RX_FERR, RX_PERR, RX_OVR,
    input  RX_ACK
  );

  modport slave (
    input  RX_DATA, RX_RDY, RX_FERR, RX_PERR, RX_OVR,
    output RX_ACK
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, 8 data bits LSB first, optional parity, 1 stop bit.
// Frames complete mid stop bit so the next start edge can be caught without slip.
module uart_rx_core #(
  parameter int unsigned P_SYNC_STAGES = 2  // must be >= 2
) (
  input  logic             FPGA_CLK,
  input  logic             FPGA_RST_N,
  input  logic             BAUD_TICK,
  input  logic             RXD,
  input  logic             PAR_EN,
  input  logic             PAR_ODD,
  uart_rx_core_if.master   host
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  state_t              state_q;
  logic [P_SYNC_STAGES-1:0] sync_q;
  logic                rxs;
  logic [TICK_W-1:0]   tick_q;
  logic [TICK_W-1:0]   tick_nxt_c;
  logic [BIT_W-1:0]    bit_q;
  logic                s7_q;
  logic                s8_q;
  logic                maj_c;
  logic [DATA_W-1:0]   shift_q;
  logic                par_en_q;
  logic                par_odd_q;
  logic                perr_calc_q;
  logic [DATA_W-1:0]   data_q;
  logic                rdy_q;
  logic                ferr_q;
  logic                perr_q;
  logic                ovr_q;

  // Metastability synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[P_SYNC_STAGES-2:0], RXD};
    end
  end

  assign rxs        = sync_q[P_SYNC_STAGES-1];
  // Tick index this BAUD_TICK represents; start-detect tick is tick 0.
  assign tick_nxt_c = TICK_W'(tick_q + TICK_W'(1));
  // 2-of-3 vote over ticks 7, 8 and the live sample on tick 9.
  assign maj_c      = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);

  // Frame FSM, bit recovery and host handshake with registered outputs.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      perr_calc_q <= 1'b0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      // Acknowledge of a pending byte; a same-cycle completion below overrides rdy.
      if (host.RX_ACK && rdy_q) begin
        rdy_q <= 1'b0;
        ovr_q <= 1'b0;
      end

      if (BAUD_TICK) begin
        if (state_q != IDLE && state_q != BRK) begin
          tick_q <= tick_nxt_c;
        end
        if (tick_nxt_c == TICK_W'(7)) s7_q <= rxs;
        if (tick_nxt_c == TICK_W'(8)) s8_q <= rxs;

        unique case (state_q)
          IDLE: begin
            if (!rxs) begin
              state_q <= START;
              tick_q  <= '0;
            end
          end
          START: begin
            if (tick_nxt_c == TICK_W'(9) && maj_c) begin
              state_q <= IDLE;
            end else if (tick_nxt_c == TICK_W'(15)) begin
              state_q   <= DATA;
              bit_q     <= '0;
              par_en_q  <= PAR_EN;
              par_odd_q <= PAR_ODD;
            end
          end
          DATA: begin
            if (tick_nxt_c == TICK_W'(9)) begin
              shift_q[bit_q] <= maj_c;
            end
            if (tick_nxt_c == TICK_W'(15)) begin
              bit_q <= BIT_W'(bit_q + BIT_W'(1));
              if (bit_q == BIT_W'(7)) begin
                state_q <= par_en_q ? PARITY : STOP;
              end
            end
          end
          PARITY: begin
            if (tick_nxt_c == TICK_W'(9)) begin
              perr_calc_q <= (^shift_q) ^ maj_c ^ par_odd_q;
            end
            if (tick_nxt_c == TICK_W'(15)) begin
              state_q <= STOP;
            end
          end
          STOP: begin
            if (tick_nxt_c == TICK_W'(9)) begin
              data_q  <= shift_q;
              ferr_q  <= ~maj_c;
              perr_q  <= par_en_q & perr_calc_q;
              rdy_q   <= 1'b1;
              if (rdy_q && !host.RX_ACK) begin
                ovr_q <= 1'b1;
              end
              state_q <= maj_c ? IDLE : BRK;
            end
          end
          BRK: begin
            if (rxs) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign host.RX_DATA = data_q;
  assign host.RX_RDY  = rdy_q;
  assign host.RX_FERR = ferr_q;
  assign host.RX_PERR = perr_q;
  assign host.RX_OVR  = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are driven at 16 ticks per bit,
// expected host-side results are queued at drive time and compared on delivery.
module tb_uart_rx_core;

  logic FPGA_CLK   = 1'b0;
  logic FPGA_RST_N;
  logic BAUD_TICK  = 1'b0;
  logic RXD;
  logic PAR_EN;
  logic PAR_ODD;

  uart_rx_core_if bus ();

  uart_rx_core #(.P_SYNC_STAGES(2)) dut (
    .FPGA_CLK   (FPGA_CLK),
    .FPGA_RST_N (FPGA_RST_N),
    .BAUD_TICK  (BAUD_TICK),
    .RXD        (RXD),
    .PAR_EN     (PAR_EN),
    .PAR_ODD    (PAR_ODD),
    .host       (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   div    = 0;

  always #5 FPGA_CLK = ~FPGA_CLK;

  // One-clock BAUD_TICK every 4 clocks, changed on the falling edge.
  always @(negedge FPGA_CLK) begin
    div       = (div + 1) % 4;
    BAUD_TICK = (div == 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the posedge that carried the n-th BAUD_TICK.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge FPGA_CLK);
      while (BAUD_TICK !== 1'b1) @(posedge FPGA_CLK);
    end
    #1;
  endtask

  function automatic logic par_err(input logic [7:0] d, input logic pbit, input logic odd);
    return (^d) ^ pbit ^ odd;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic ferr, input logic perr, input logic ovr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    e.perr = perr;
    e.ovr  = ovr;
    sb.push_back(e);
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop bit; line left at stop level.
  // ack_at_done pulses RX_ACK on the clock the stop bit is decided (10 ticks into it).
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input bit ack_at_done);
    wait_ticks(1);
    RXD = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      wait_ticks(16);
    end
    if (PAR_EN) begin
      RXD = pbit;
      wait_ticks(16);
    end
    RXD = stop;
    if (ack_at_done) begin
      wait_ticks(9);
      repeat (3) @(posedge FPGA_CLK);
      #1 bus.RX_ACK = 1'b1;
      @(posedge FPGA_CLK);
      #1 bus.RX_ACK = 1'b0;
      wait_ticks(6);
    end else begin
      wait_ticks(16);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check_eq({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({tag, "_rdy"},  32'(bus.RX_RDY),  32'd1);
      check_eq({tag, "_data"}, 32'(bus.RX_DATA), 32'(e.data));
      check_eq({tag, "_ferr"}, 32'(bus.RX_FERR), 32'(e.ferr));
      check_eq({tag, "_perr"}, 32'(bus.RX_PERR), 32'(e.perr));
      check_eq({tag, "_ovr"},  32'(bus.RX_OVR),  32'(e.ovr));
    end
  endtask

  task automatic do_ack();
    bus.RX_ACK = 1'b1;
    @(posedge FPGA_CLK);
    #1 bus.RX_ACK = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_data"}, 32'(bus.RX_DATA), 32'h00);
    check_eq({tag, "_rdy"},  32'(bus.RX_RDY),  32'd0);
    check_eq({tag, "_ferr"}, 32'(bus.RX_FERR), 32'd0);
    check_eq({tag, "_perr"}, 32'(bus.RX_PERR), 32'd0);
    check_eq({tag, "_ovr"},  32'(bus.RX_OVR),  32'd0);
  endtask

  initial begin
    RXD        = 1'b1;
    PAR_EN     = 1'b0;
    PAR_ODD    = 1'b0;
    bus.RX_ACK = 1'b0;
    FPGA_RST_N = 1'b0;
    #23;
    check_reset_vals("reset");
    @(negedge FPGA_CLK);
    FPGA_RST_N = 1'b1;
    wait_ticks(4);

    // 8N1 byte, then acknowledge
    push_exp(8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    pop_check("8n1_55");
    do_ack();
    check_eq("8n1_ack_rdy", 32'(bus.RX_RDY), 32'd0);

    // Even then odd parity on 0xA3
    PAR_EN  = 1'b1;
    PAR_ODD = 1'b0;
    push_exp(8'hA3, 1'b0, par_err(8'hA3, 1'b0, 1'b0), 1'b0);
    send_frame(8'hA3, 1'b0, 1'b1, 1'b0);
    pop_check("even_ok");
    do_ack();
    push_exp(8'hA3, 1'b0, par_err(8'hA3, 1'b1, 1'b0), 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    pop_check("even_bad");
    do_ack();
    PAR_ODD = 1'b1;
    push_exp(8'hA3, 1'b0, par_err(8'hA3, 1'b1, 1'b1), 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    pop_check("odd_ok");
    do_ack();
    PAR_EN  = 1'b0;
    PAR_ODD = 1'b0;

    // Short low glitch is a false start
    RXD = 1'b0;
    wait_ticks(4);
    RXD = 1'b1;
    wait_ticks(20);
    check_eq("glitch_rdy", 32'(bus.RX_RDY), 32'd0);
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    pop_check("after_glitch_3c");
    do_ack();

    // Framing error, then break held for three frame times
    push_exp(8'h81, 1'b1, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    pop_check("ferr_81");
    do_ack();
    for (int f = 0; f < 3; f++) begin
      wait_ticks(160);
      check_eq("brk_hold_rdy", 32'(bus.RX_RDY), 32'd0);
    end
    RXD = 1'b1;
    wait_ticks(20);
    check_eq("brk_release_rdy", 32'(bus.RX_RDY), 32'd0);
    push_exp(8'h7E, 1'b0, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0);
    pop_check("after_brk_7e");
    do_ack();

    // Overrun and its clearing by acknowledge
    push_exp(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    pop_check("ovr_first");
    push_exp(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    pop_check("ovr_second");
    do_ack();
    check_eq("ovr_ack_ovr", 32'(bus.RX_OVR), 32'd0);
    check_eq("ovr_ack_rdy", 32'(bus.RX_RDY), 32'd0);

    // Acknowledge on the completion clock: new byte wins, no overrun
    push_exp(8'h33, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    pop_check("pre_coinc_33");
    push_exp(8'h44, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1, 1'b1);
    pop_check("coinc_44");

    // Reset during data bit 4 aborts the frame
    wait_ticks(1);
    RXD = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      RXD = (8'hC9 >> i) & 8'h01;
      wait_ticks(16);
    end
    RXD = 1'b0;
    wait_ticks(8);
    FPGA_RST_N = 1'b0;
    #2;
    check_reset_vals("midframe_reset");
    RXD = 1'b1;
    @(negedge FPGA_CLK);
    FPGA_RST_N = 1'b1;
    wait_ticks(100);
    check_eq("abort_no_byte_rdy", 32'(bus.RX_RDY), 32'd0);
    push_exp(8'hC9, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC9, 1'b0, 1'b1, 1'b0);
    pop_check("after_reset_c9");
    do_ack();
    check_eq("final_rdy", 32'(bus.RX_RDY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receive core consuming the 16x oversampling pulse from the baud-rate generator. Recovers 8-bit asynchronous frames from the serial input line, LSB first, with 1 stop bit and optional even/odd parity. Presents each byte to the host register logic through a ready/acknowledge handshake. Flags framing, parity and overrun errors. Sits between the IO pin synchroniser boundary and the SIF register block, in the FPGA_CLK domain.

## Interface
- P_SYNC_STAGES, 2, number of RXD synchroniser flops; minimum 2.
- FPGA_CLK  in  1  system clock.
- FPGA_RST_N  in  1  asynchronous reset, active low.
- BAUD_TICK  in  1  16x baud pulse, one FPGA_CLK wide.
- RXD  in  1  serial line, asynchronous, idle high.
- PAR_EN  in  1  1 = parity bit present after D7.
- PAR_ODD  in  1  1 = odd parity, 0 = even parity; ignored when PAR_EN=0.
- RX_ACK  in  1  host acknowledge, one-clock pulse; clears RX_RDY.
- RX_DATA  out  8  last received byte.
- RX_RDY  out  1  byte available, level.
- RX_FERR  out  1  stop bit sampled 0 for the byte in RX_DATA.
- RX_PERR  out  1  parity mismatch for the byte in RX_DATA; 0 when PAR_EN=0.
- RX_OVR  out  1  sticky: a byte was overwritten before RX_ACK.

## Operation
- RXD passes through P_SYNC_STAGES flops; every stage resets to 1. All other logic uses the synchronised value rxs.
- Tick counter: 4-bit, advances only on BAUD_TICK, wraps 15→0. Bit counter: 3-bit.
- Majority sampling: rxs is captured on ticks 7, 8 and 9 of each bit. The bit value is the 2-of-3 majority and is decided on tick 9.
- States: IDLE, START, DATA, PARITY, STOP, BRK.
- IDLE: on BAUD_TICK with rxs=0, go to START. The tick counter is set to 0 on that tick.
- START: the majority decision on tick 9 of 1 is a false start; return to IDLE. On tick 15 go to DATA with the bit counter at 0.
- DATA: on each tick 9, shift the majority into bit position [bit counter]. On tick 15 increment the bit counter. After bit 7, go to PARITY if PAR_EN=1, else go to STOP.
- PARITY: on tick 9 compute perr = (^data ^ bit ^ PAR_ODD) ≠ 0. On tick 15 go to STOP.
- STOP: the frame completes on tick 9, with no wait for tick 15 (allows resynchronisation to the next start edge). At completion:
  - RX_DATA is loaded.
  - RX_FERR is set to the inverted stop majority.
  - RX_PERR is set to perr, or 0 when PAR_EN=0.
  - RX_RDY is set to 1.
  - Next state is IDLE if stop=1, BRK if stop=0.
- BRK: stay until a BAUD_TICK with rxs=1, then go to IDLE. A line held low yields exactly one byte (0x00, FERR=1).
- The byte is delivered on framing error; no frame is ever silently dropped.
- Handshake:
  - RX_ACK with RX_RDY=1 clears RX_RDY and RX_OVR on the next clock.
  - RX_ACK with RX_RDY=0 has no effect.
- Overrun: completion while RX_RDY=1 and RX_ACK=0 overwrites RX_DATA, RX_FERR and RX_PERR, keeps RX_RDY=1 and sets RX_OVR.
- Completion in the same clock as RX_ACK: the new byte wins. RX_RDY stays 1, RX_OVR is cleared and not set.
- PAR_EN and PAR_ODD are sampled on the START→DATA transition and held for the frame.
- Reset mid-frame aborts the frame; no byte is delivered.

## Timing
- Reset values:
  - RX_DATA = 0x00.
  - RX_RDY, RX_FERR, RX_PERR and RX_OVR = 0.
  - State IDLE; both counters 0.
- Registered outputs change one FPGA_CLK after the deciding BAUD_TICK clock edge.
- Latency, counted in BAUD_TICKs after the start-detect tick:
  - Stop decision at tick 153 without parity, 169 with parity.
  - RX_RDY rises one FPGA_CLK later.
- RXD-to-rxs delay is P_SYNC_STAGES clocks. That is negligible against 16 ticks per bit as long as BAUD_TICK spacing is at least 2 clocks (the 3 Mbps setting gives 2).
- Ticks arriving while in BRK or IDLE with rxs=1 do nothing.

## Test plan
- 8N1 0x55 at 16 ticks per bit, then RX_ACK -> RX_RDY=1, RX_DATA=0x55, FERR=PERR=OVR=0; RX_RDY=0 one clock after ACK.
- PAR_EN=1, PAR_ODD=0, byte 0xA3:
  - parity bit 0 -> PERR=0.
  - parity bit 1 -> PERR=1, RX_DATA=0xA3.
- RXD low for 4 ticks, then high -> no state change beyond START, RX_RDY stays 0. A following valid 0x3C frame is received correctly.
- Stop bit driven 0 on byte 0x81 -> RX_DATA=0x81, FERR=1. Line then held low for 3 frame times -> no second RX_RDY until RXD returns high. The next frame 0x7E is received with FERR=0.
- Two frames 0x11, 0x22 with no RX_ACK -> RX_DATA=0x22, RX_OVR=1. Then ACK -> RX_OVR=0, RX_RDY=0. ACK coincident with completion -> RX_RDY=1, RX_OVR=0.
- FPGA_RST_N pulsed low during DATA bit 4 -> all outputs at reset values asynchronously. After release, a new 0xC9 frame is received correctly.
